// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed hex display scanner with anti-ghost guard blanking and frame-synchronous update.
// Optional leading-zero blanking is enabled by defining SSEG_LZB_EN.
module sseg_scan_ctrl #(
    parameter int DIV   = 100000,
    parameter int GUARD = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [15:0]      disp, disp_nxt;
    logic [15:0]      pend, pend_nxt;
    logic             pf, pf_nxt;
    logic             tick_q;
    logic             boundary;
    logic             lit;

    assign boundary = (state == SCAN) && (idx == 2'd3) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= BLANK;
            cnt    <= '0;
            idx    <= 2'd0;
            disp   <= 16'h0000;
            pend   <= 16'h0000;
            pf     <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            disp   <= disp_nxt;
            pend   <= pend_nxt;
            pf     <= pf_nxt;
            tick_q <= boundary;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        disp_nxt  = disp;
        pend_nxt  = pend;
        pf_nxt    = pf;

        case (state)
            BLANK: begin
                if (enable) begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                    idx_nxt   = 2'd0;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = 2'd0;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    idx_nxt = idx + 2'd1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = BLANK;
            end
        endcase

        // Display only changes between frames while scanning, so a frame never mixes two values.
        if (boundary) begin
            if (load) begin
                disp_nxt = value;
                pf_nxt   = 1'b0;
            end else if (pf) begin
                disp_nxt = pend;
                pf_nxt   = 1'b0;
            end
        end else if (state == SCAN) begin
            if (load) begin
                pend_nxt = value;
                pf_nxt   = 1'b1;
            end
        end else if (load) begin
            disp_nxt = value;
            pf_nxt   = 1'b0;
        end
    end

`ifdef SSEG_LZB_EN
    always_comb begin
        case (idx)
            2'd0:    lit = 1'b1;
            2'd1:    lit = |disp[15:4];
            2'd2:    lit = |disp[15:8];
            default: lit = |disp[15:12];
        endcase
    end
`else
    assign lit = 1'b1;
`endif

    assign digit      = disp[{idx, 2'b00} +: 4];
    assign an         = ((state == SCAN) && (cnt >= CNT_GUARD) && lit) ? ~(4'b0001 << idx) : 4'b1111;
    assign frame_tick = tick_q && (state == SCAN);

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl: a time-based reference model predicts every cycle's outputs.
module tb_sseg_scan_ctrl;

    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] digit;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: scan position is derived from cycles elapsed since scanning began.
    bit          m_scan    = 1'b0;
    int          t         = 0;
    logic [15:0] shown     = 16'h0000;
    logic [15:0] pend_val  = 16'h0000;
    bit          pend_flag = 1'b0;

    sseg_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .digit      (digit),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    function automatic exp_t predict(input bit tick);
        exp_t e;
        int   slot;
        int   ph;
        bit   lighted;
        slot = (t / DIV) % 4;
        ph   = t % DIV;
`ifdef SSEG_LZB_EN
        lighted = (slot == 0) || ((shown >> (4 * slot)) != 16'h0000);
`else
        lighted = 1'b1;
`endif
        e.an = 4'hF;
        if (m_scan && ph >= GUARD && lighted) e.an[slot] = 1'b0;
        e.digit = shown[4 * slot +: 4];
        e.tick  = tick;
        return e;
    endfunction

    always @(posedge clk) begin : model
        bit boundary;
        bit tick;
        tick = 1'b0;
        if (rst) begin
            m_scan    = 1'b0;
            t         = 0;
            shown     = 16'h0000;
            pend_val  = 16'h0000;
            pend_flag = 1'b0;
        end else begin
            boundary = m_scan && ((t % FRAME) == FRAME - 1);
            if (boundary) begin
                if (load) shown = value;
                else if (pend_flag) shown = pend_val;
                pend_flag = 1'b0;
            end else if (m_scan) begin
                if (load) begin
                    pend_val  = value;
                    pend_flag = 1'b1;
                end
            end else if (load) begin
                shown     = value;
                pend_flag = 1'b0;
            end
            tick = boundary && enable;
            if (m_scan && enable) begin
                t = t + 1;
            end else begin
                m_scan = enable;
                t      = 0;
            end
        end
        exp_q.push_back(predict(tick));
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rst) e = '{an: 4'hF, digit: 4'h0, tick: 1'b0};
            tests++;
            if ({an, digit, frame_tick} !== e) begin
                fails++;
                $display("FAIL scan_out @%0t: an=%b digit=%h tick=%b, expected an=%b digit=%h tick=%b",
                         $time, an, digit, frame_tick, e.an, e.digit, e.tick);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
    endtask

    task automatic wait_slot(input int s, input int ph);
        int n;
        n = 0;
        while (!(m_scan && ((t / DIV) % 4) == s && (t % DIV) == ph)) begin
            step(1);
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL wait_slot timeout: slot %0d phase %0d not reached", s, ph);
                return;
            end
        end
    endtask

    task automatic check_now(input string name, input logic [3:0] act, input logic [3:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        value  = 16'h0000;
        #1;
        check_now("reset_an", an, 4'hF);
        check_now("reset_digit", digit, 4'h0);
        check_now("reset_tick", {3'b000, frame_tick}, 4'h0);

        step(2);
        rst = 1'b0;
        step(1);
        pulse_load(16'h1234);
        enable = 1'b1;
        step(2 * FRAME + 4);

        wait_slot(1, 3);
        pulse_load(16'hABCD);
        wait_slot(2, 3);
        pulse_load(16'h5678);
        step(2 * FRAME);

        wait_slot(1, 0);
        pulse_load(16'h1111);
        wait_slot(3, DIV - 1);
        pulse_load(16'h9999);
        step(2 * FRAME);

        wait_slot(2, 4);
        enable = 1'b0;
        step(1);
        check_now("disable_an", an, 4'hF);
        step(4);
        enable = 1'b1;
        step(FRAME + 8);

        wait_slot(0, 5);
        pulse_load(16'h0042);
        step(2 * FRAME);
        pulse_load(16'h0000);
        step(2 * FRAME);
        pulse_load(16'h0300);
        step(2 * FRAME);

        wait_slot(3, 0);
        pulse_load(16'hBEEF);
        wait_slot(1, 4);
        #2;
        rst = 1'b1;
        #1;
        check_now("async_rst_an", an, 4'hF);
        check_now("async_rst_digit", digit, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2 * FRAME);

        for (int i = 0; i < 800; i++) begin
            if (enable && $urandom_range(0, 99) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            load  = ($urandom_range(0, 15) == 0);
            value = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
            step(1);
        end
        load = 1'b0;
        step(3);
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 100000, clock cycles per digit slot (legal range DIV >= 4).
REQ-002 SHALL have parameter GUARD, default 1000, anti-ghost blank cycles at the start of each slot (legal range 1 <= GUARD < DIV).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  1 = scan display, 0 = blank display and hold scan at slot 0.
REQ-006 SHALL have port load  input  1  single-cycle strobe that captures value.
REQ-007 SHALL have port value  input  16  four hex nibbles; digit 0 = value[3:0], digit 3 = value[15:12].
REQ-008 SHALL have port digit  output  4  nibble for the external hex-to-segment decoder (active-low segments).
REQ-009 SHALL have port an  output  4  active-low digit anodes; an[i] low lights digit i.
REQ-010 SHALL have port frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-011 SHALL hold internal state {BLANK, SCAN}, slot counter cnt (0..DIV-1, width ceil(log2(DIV))), digit index idx (0..3), display register disp[15:0], pending register pend[15:0] and pending flag pf.
REQ-012 SHALL transition BLANK->SCAN on the first clk edge with enable=1, and SCAN->BLANK on the first clk edge with enable=0; both transitions load cnt=0 and idx=0.
REQ-013 SHALL, in SCAN, increment cnt every cycle; when cnt=DIV-1, cnt wraps to 0 and idx advances by 1 modulo 4.
REQ-014 SHALL define the frame boundary as the SCAN cycle with idx=3 and cnt=DIV-1; frame_tick is 1 during the following cycle only (idx=0, cnt=0).
REQ-015 SHALL drive an and digit combinationally from registered state only: an[idx]=0 iff state=SCAN and cnt>=GUARD and the digit is not blanked; all other anode bits are 1.
REQ-016 SHALL drive digit = disp nibble selected by idx in every cycle, including guard and BLANK cycles.
REQ-017 SHALL, in SCAN on a load cycle that is not the frame boundary, write value to pend and set pf; a later load before the boundary overwrites pend (last wins).
REQ-018 SHALL, at the frame boundary with pf=1, copy pend to disp and clear pf, so a displayed frame never mixes old and new nibbles.
REQ-019 SHALL, when load coincides with the frame boundary, write value directly to disp and clear pf; the new value wins over any older pend.
REQ-020 SHALL, in BLANK, write value directly to disp on load and clear pf.
REQ-021 SHALL give frame_tick and disp-transfer priority over nothing else; enable=0 in the boundary cycle still performs the REQ-018/019 transfer, but frame_tick is not asserted because the state is then BLANK.

Reset
REQ-022 SHALL, while rst=1 and independent of clk, force state=BLANK, cnt=0, idx=0, disp=0, pend=0, pf=0, giving an=4'b1111, digit=4'h0, frame_tick=0.
REQ-023 SHALL, when rst asserts mid-scan, blank all anodes immediately and discard any pending value.

Configuration
REQ-024 SHALL, with SSEG_LZB_EN defined, blank digit i (i=3..1) when disp[4i+3:4i] and all higher nibbles are zero; digit 0 is never blanked.
REQ-025 SHALL, without SSEG_LZB_EN, light all four digits in their slots regardless of value.

Verification (DIV=8, GUARD=2)
REQ-026 SHALL check: rst=1 with no clock -> an=1111, digit=0, frame_tick=0; release with enable=1 -> an=1110 first appears at cnt=2.
REQ-027 SHALL check: load 0x1234 in BLANK, then enable -> slots show digit 4,3,2,1 with an 1110,1101,1011,0111, each low for 6 of 8 cycles; frame_tick high once per 32 cycles.
REQ-028 SHALL check: display 0x1234, then load 0xABCD at idx=1 followed by 0x5678 at idx=2 -> the rest of the frame still shows 0x1234; the next frame shows 8,7,6,5.
REQ-029 SHALL check: load 0x9999 exactly in the frame-boundary cycle -> the next frame shows 9,9,9,9, and pf=0 afterwards.
REQ-030 SHALL check: enable dropped at idx=2 -> an=1111 after the next edge; re-enable -> scan restarts at idx=0, cnt=0.
REQ-031 SHALL check: with SSEG_LZB_EN, 0x0042 -> an[3] and an[2] stay 1, and 0x0000 -> only an[0] pulses; without the macro, all four anodes pulse for both values.
